// File: rtl/print_uart_pkg.sv
// print_uart_pkg: shared types and field positions for the console UART transmitter
package print_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int UART_DATA_BITS = 8;
  localparam int PRINT_W = 49;
  localparam int PRINT_VALID_BIT = 48;
  localparam int PRINT_CHAR_LSB = 0;
endpackage

// File: rtl/print_char_fifo.sv
// print_char_fifo: first-word fall-through sync FIFO (push/din, pop/dout, full, empty, level)
module print_char_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level = wr_q - rd_q;
  assign dout = mem[rd_q[AW-1:0]];
  // a push into a full FIFO still lands when the head leaves on the same edge
  assign do_push = push && (!full || pop);
  assign do_pop = pop && !empty;
  always_comb begin
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/print_uart_tx.sv
// print_uart_tx: buffers strobed console characters and sends them as 8N1 UART frames (clk, resetn, print_in -> uart_tx, busy, fifo_level, overflow)
module print_uart_tx
  import print_uart_pkg::*;
#(
  parameter int CLK_DIV = 868,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW = $clog2(FIFO_DEPTH)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [PRINT_W-1:0] print_in,
  output logic               uart_tx,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow
);
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
  state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d, head;
  logic tx_q, tx_d, overflow_q, overflow_d;
  logic push, pop, full, empty, expire, unused_print;
  assign push = print_in[PRINT_VALID_BIT];
  assign unused_print = ^print_in[PRINT_VALID_BIT-1:PRINT_CHAR_LSB+UART_DATA_BITS];
  assign expire = baud_q == '0;
  print_char_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .resetn(resetn), .push(push), .din(print_in[PRINT_CHAR_LSB +: UART_DATA_BITS]),
    .pop(pop), .dout(head), .full(full), .empty(empty), .level(fifo_level)
  );
  always_comb begin
    state_d = state_q;
    baud_d = state_q == IDLE ? baud_q : (expire ? BAUD_MAX : baud_q - 1'b1);
    bit_d = bit_q;
    shift_d = shift_q;
    tx_d = tx_q;
    // a new frame starts from idle, or straight out of an expiring stop bit
    pop = !empty && (state_q == IDLE || (state_q == STOP && expire));
    case (state_q)
      START: if (expire) begin
        state_d = DATA;
        bit_d = '0;
        tx_d = shift_q[0];
      end
      DATA: if (expire) begin
        state_d = bit_q == 3'd7 ? STOP : DATA;
        bit_d = bit_q + 3'd1;
        shift_d = shift_q >> 1;
        tx_d = bit_q == 3'd7 ? 1'b1 : shift_q[1];
      end
      STOP: if (expire && empty) state_d = IDLE;
      default: ;
    endcase
    if (pop) begin
      state_d = START;
      shift_d = head;
      baud_d = BAUD_MAX;
      tx_d = 1'b0;
    end
    overflow_d = overflow_q || (push && full && !pop);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      overflow_q <= overflow_d;
    end
  assign uart_tx = tx_q;
  assign overflow = overflow_q;
  assign busy = state_q != IDLE || fifo_level != '0;
endmodule

// File: tb/tb_print_uart_tx.sv
// tb_print_uart_tx: randomized check of print_uart_tx against a frame-timeline reference model
module tb_print_uart_tx;
  localparam int CD = 4;
  localparam int DEPTH = 4;
  localparam int AW = 2;
  localparam int FRAME = 10 * CD;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic [48:0] print_in = '0;
  logic uart_tx, busy, overflow;
  logic [AW:0] fifo_level;
  int errors = 0;
  int checks = 0;
  int q[$];
  bit m_active, m_ovf;
  int m_t, m_cur;
  print_uart_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .print_in(print_in), .uart_tx(uart_tx),
    .busy(busy), .fifo_level(fifo_level), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic exp_tx();
    int fb;
    if (!m_active) return 1'b1;
    fb = m_t / CD;
    if (fb == 0) return 1'b0;
    if (fb == 9) return 1'b1;
    return 1'((m_cur >> (fb - 1)) & 1);
  endfunction
  task automatic model_reset();
    q.delete();
    m_active = 0;
    m_t = 0;
    m_ovf = 0;
  endtask
  task automatic model_edge(input bit s, input int c);
    bit p;
    p = q.size() != 0 && (!m_active || m_t == FRAME - 1);
    if (m_active) begin
      m_t++;
      if (m_t == FRAME) m_active = 0;
    end
    if (p) begin
      m_cur = q.pop_front();
      m_active = 1;
      m_t = 0;
    end
    if (s) begin
      if (q.size() == DEPTH) m_ovf = 1;
      else q.push_back(c);
    end
  endtask
  task automatic compare_all();
    check("uart_tx", uart_tx, exp_tx());
    check("busy", busy, (m_active || q.size() != 0) ? 1 : 0);
    check("fifo_level", fifo_level, q.size());
    check("overflow", overflow, m_ovf);
  endtask
  task automatic cycle(input bit s, input int c);
    logic [39:0] junk;
    junk = {$urandom, $urandom};
    print_in = {s, junk, 8'(c)};
    @(posedge clk);
    if (resetn) model_edge(s, c);
    #1;
    compare_all();
  endtask
  task automatic idle(input int n);
    repeat (n) cycle(0, $urandom_range(0, 255));
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    #1;
    compare_all();
    repeat (3) cycle(0, 0);
    resetn = 1'b1;
  endtask
  task automatic wait_bit(input int t_target, input string tag);
    int n;
    n = 0;
    while (!(m_active && m_t == t_target) && n < 3 * FRAME) begin
      cycle(0, 0);
      n++;
    end
    if (n >= 3 * FRAME) check(tag, 0, 1);
  endtask
  initial begin
    #2;
    do_reset();
    cycle(1, 8'h41);
    idle(FRAME + 5);
    check("single_done", busy, 0);
    cycle(1, 8'h48);
    cycle(1, 8'h69);
    cycle(1, 8'h0A);
    check("burst_peak", fifo_level, 2);
    idle(3 * FRAME + 5);
    print_in = {1'b0, 40'h0, 8'hFF};
    repeat (100) begin
      @(posedge clk);
      #1;
      compare_all();
    end
    check("nostrobe_tx", uart_tx, 1);
    for (int i = 0; i < 6; i++) cycle(1, 8'h30 + i);
    check("ovf_set", overflow, 1);
    idle(5 * FRAME + 5);
    check("ovf_sticky", overflow, 1);
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 8'h60 + i);
    check("full_lvl", fifo_level, DEPTH);
    wait_bit(FRAME - 1, "wait_stop");
    cycle(1, 8'hA5);
    check("fullpop_lvl", fifo_level, DEPTH);
    check("fullpop_ovf", overflow, 0);
    idle(6 * FRAME);
    check("fullpop_idle", busy, 0);
    do_reset();
    repeat (400) cycle($urandom_range(0, 29) == 0, $urandom_range(0, 255));
    idle(DEPTH * FRAME + FRAME);
    cycle(1, 8'hC3);
    wait_bit(4 * CD + 1, "wait_bit3");
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check("rst_tx", uart_tx, 1);
    check("rst_busy", busy, 0);
    compare_all();
    repeat (2) cycle(0, 0);
    resetn = 1'b1;
    cycle(1, 8'h55);
    idle(FRAME + 5);
    check("after_rst", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/print_uart_tx.md
Name: print_uart_tx

Overview:
- Downstream consumer of the core wrapper's 49-bit `print_out` console stream (bit 48 = valid strobe, bits 7:0 = character).
- Buffers each strobed character in a small synchronous FIFO and serialises it on a UART line: 8N1 format, LSB first.
- Sits at the top level between the core wrapper and the board TX pin, so firmware console output becomes visible without a debugger.

Parameters:
- CLK_DIV, 868, clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- FIFO_DEPTH, 16, character buffer entries; power of two, ≥ 2.
- FIFO_AW, $clog2(FIFO_DEPTH), FIFO address width (derived; do not override).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- resetn  in  1  asynchronous active-low reset.
- print_in  in  49  console word; [48] = strobe, [47:8] ignored, [7:0] = character.
- uart_tx  out  1  serial line, idles high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_level  out  FIFO_AW+1  current FIFO occupancy, 0..FIFO_DEPTH.
- overflow  out  1  sticky; set when a strobed character is dropped because the FIFO is full.

Behaviour:
- Reset (async assert, sync-released use):
  - uart_tx=1, busy=0, fifo_level=0, overflow=0.
  - FSM enters IDLE; FIFO pointers, bit counter and baud counter all 0.
  - Reset asserted mid-frame: uart_tx returns high immediately and the in-flight character is discarded.
- Capture:
  - Every cycle with print_in[48]=1 pushes print_in[7:0] at that rising edge.
  - print_in[48]=0: no push, regardless of the data bits.
  - Consecutive strobe cycles push one character each.
- Full FIFO:
  - A push while full and with no same-edge pop is dropped, and overflow sets on that edge.
  - overflow clears only on reset.
  - Push and pop on the same edge are both performed; fifo_level is unchanged and no overflow occurs, even when full.
- Empty FIFO: pop never occurs.
- FSM states, with one baud counter counting CLK_DIV-1..0 per bit:
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop the head into the shift register, load the baud counter, drive uart_tx=0 on the same edge, go to START.
  - START: hold 0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: uart_tx=shift[0] for CLK_DIV cycles per bit, shift right after each bit; after bit 7, go to STOP.
  - STOP: uart_tx=1 for CLK_DIV cycles. At expiry, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Latency: strobe sampled at edge E0 → uart_tx falls at edge E1 (FIFO empty, FSM idle).
- Frame length is exactly 10*CLK_DIV cycles; back-to-back frames are contiguous.
- uart_tx is driven from a flop, so there are no combinational glitches.
- busy = (state≠IDLE) | (fifo_level≠0), registered-equivalent. It deasserts on the edge where STOP ends with an empty FIFO.
- Widths:
  - Baud counter: $clog2(CLK_DIV) bits.
  - Bit index: 3 bits.
  - FIFO pointers: FIFO_AW+1 bits with wrap bit; full/empty are derived from pointer compare.

Decomposition:
- Package print_uart_pkg:
  - state enum {IDLE, START, DATA, STOP}
  - UART_DATA_BITS=8
  - PRINT_W=49
  - PRINT_VALID_BIT=48
  - PRINT_CHAR_LSB=0
- Sub-module print_char_fifo:
  - Synchronous FIFO, parameters WIDTH=8 and DEPTH.
  - Ports: push/din, pop/dout (first-word fall-through), full, empty, level.
  - Same async active-low reset.
- Top module holds the capture logic, FSM, baud counter and overflow flag.

Test Plan:
- Single character, CLK_DIV=4: one strobe of print_in={1'b1,40'h0,8'h41} → uart_tx falls one cycle later and carries 0,1,0,0,0,0,0,1,0,1 (start, LSB-first 0x41, stop), each level held 4 cycles; busy high for 40 cycles, then low.
- Burst, CLK_DIV=4: three consecutive strobes "H","i","\n" (0x48, 0x69, 0x0A) → fifo_level peaks at 2, three contiguous 40-cycle frames with no idle gap, all bytes correct.
- Non-strobe filtering: print_in={1'b0,40'h0,8'hFF} held for 100 cycles → uart_tx stays 1, fifo_level=0, busy=0.
- Overflow, FIFO_DEPTH=4, CLK_DIV=8: six back-to-back strobes 0x30..0x35:
  - First pops immediately and the next four fill the FIFO, so the sixth (0x35) is dropped and overflow=1.
  - Line carries 0x30..0x34.
  - overflow stays 1 until reset.
- Full with simultaneous pop: FIFO full, strobe on the exact edge STOP expires → no overflow, fifo_level unchanged, new byte transmitted last.
- Reset mid-frame: assert resetn=0 during DATA bit 3 → uart_tx=1 asynchronously and all outputs at reset values. After release, a new strobe of 0x55 produces a clean frame.
